// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: runs a 1-bit halfadder pair plus carry flop over WIDTH bits, LSB first.
// Optional macro CARRY_IN_EN adds a cin port that seeds the carry flop on an accepted start.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef CARRY_IN_EN
    input  logic             cin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             carry_ld_c;
    logic             ha0_s_c, ha0_c_c, ha1_s_c, ha1_c_c;
    logic [WIDTH-1:0] acc_shift_c;

`ifdef CARRY_IN_EN
    assign carry_ld_c = cin;
`else
    assign carry_ld_c = 1'b0;
`endif

    // Shared 1-bit datapath: ha0 adds operand bits, ha1 folds in the running carry.
    always_comb begin
        ha0_s_c     = opa_q[0] ^ opb_q[0];
        ha0_c_c     = opa_q[0] & opb_q[0];
        ha1_s_c     = ha0_s_c ^ carry_q;
        ha1_c_c     = ha0_s_c & carry_q;
        acc_shift_c = (acc_q >> 1) | (WIDTH'(ha1_s_c) << (WIDTH - 1));
    end

    // Next-state and datapath sequencing
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    opa_d   = a_in;
                    opb_d   = b_in;
                    acc_d   = '0;
                    carry_d = carry_ld_c;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d   = acc_shift_c;
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = ha0_c_c | ha1_c_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = acc_shift_c;
                    cout_d  = ha0_c_c | ha1_c_c;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit and a 1-bit instance driven with
// directed and random operands, checked against plain integer addition.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;
`ifdef CARRY_IN_EN
    localparam bit CIN_EN = 1'b1;
`else
    localparam bit CIN_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         start1;
    logic [0:0]   a1, b1;
    logic         busy1, done1, cout1;
    logic [0:0]   sum1;
`ifdef CARRY_IN_EN
    logic         cin, cin1;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
`ifdef CARRY_IN_EN
        .cin   (cin),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a_in  (a1),
        .b_in  (b1),
`ifdef CARRY_IN_EN
        .cin   (cin1),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // Launches one addition on the 8-bit instance and observes it up to the done pulse.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          output logic [W:0] res, output int busy_cyc, output bit timeout,
                          output bit overlap, output bit sum_moved);
        logic [W-1:0] sum_prev;
        logic         cout_prev;
        @(posedge clk); #1;
        start = 1'b1; a_in = a; b_in = b;
`ifdef CARRY_IN_EN
        cin = ci;
`endif
        sum_prev = sum; cout_prev = cout;
        @(posedge clk); #1;
        start = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
`ifdef CARRY_IN_EN
        cin = 1'($urandom);
`endif
        busy_cyc = 0; timeout = 1'b1; overlap = 1'b0; sum_moved = 1'b0; res = '0;
        for (int i = 0; i < 40; i++) begin
            if (busy && done) overlap = 1'b1;
            if (done) begin
                res = {cout, sum};
                timeout = 1'b0;
                break;
            end
            if (sum !== sum_prev || cout !== cout_prev) sum_moved = 1'b1;
            if (busy) busy_cyc++;
            @(posedge clk); #1;
        end
        if (ci == 1'b1 && !CIN_EN) res = res; // carry-in ignored when the port is absent
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
`ifdef CARRY_IN_EN
        cin = 1'b0; cin1 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        total++; if (sum !== '0) begin bad++; $display("FAIL reset_sum: got %h expected 00", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b expected 0", cout); end
        total++; if ({busy1, done1, sum1, cout1} !== 4'b0) begin
            bad++; $display("FAIL reset_w1: got %b expected 0000", {busy1, done1, sum1, cout1});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] av [3] = '{8'h0F, 8'hFF, 8'hA5};
        logic [W-1:0] bv [3] = '{8'h01, 8'h01, 8'h5A};
        logic [W:0]   ev [3] = '{9'h010, 9'h100, 9'h0FF};
        logic [W:0]   res;
        int bc; bit to, ov, mv;
        for (int i = 0; i < 3; i++) begin
            do_add(av[i], bv[i], 1'b0, res, bc, to, ov, mv);
            total++; if (to) begin bad++; $display("FAIL dir_timeout[%0d]: no done within budget", i); end
            total++; if (res !== ev[i]) begin
                bad++; $display("FAIL dir_result[%0d]: got cout,sum=%h expected %h", i, res, ev[i]);
            end
            total++; if (bc != W) begin bad++; $display("FAIL dir_busy[%0d]: got %0d busy cycles expected %0d", i, bc, W); end
            total++; if (ov || mv) begin
                bad++; $display("FAIL dir_stable[%0d]: got overlap=%b moved=%b expected 0 0", i, ov, mv);
            end
        end
`ifdef CARRY_IN_EN
        do_add(8'hFF, 8'h00, 1'b1, res, bc, to, ov, mv);
        total++; if (to || res !== 9'h100) begin
            bad++; $display("FAIL dir_cin: got cout,sum=%h timeout=%b expected 100", res, to);
        end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         ci;
        logic [W:0]   res, exp;
        int bc; bit to, ov, mv;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom); b = W'($urandom);
            ci = CIN_EN ? 1'($urandom) : 1'b0;
            exp = (W+1)'(int'(a) + int'(b) + int'(ci));
            do_add(a, b, ci, res, bc, to, ov, mv);
            total++; if (to || res !== exp || bc != W || ov || mv) begin
                bad++;
                $display("FAIL rand[%0d]: got %h (busy=%0d to=%b ov=%b mv=%b) expected %h (busy=%0d)",
                         i, res, bc, to, ov, mv, exp, W);
            end
        end
    endtask

    task automatic test_start_held();
        logic [W-1:0] xa, xb, ya, yb;
        logic [W:0]   ex, ey;
        int bc; bit got;
        xa = W'($urandom); xb = W'($urandom); ya = W'($urandom); yb = W'($urandom);
        ex = (W+1)'(int'(xa) + int'(xb));
        ey = (W+1)'(int'(ya) + int'(yb));
`ifdef CARRY_IN_EN
        cin = 1'b0;
`endif
        @(posedge clk); #1;
        start = 1'b1; a_in = xa; b_in = xb;
        @(posedge clk); #1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin got = 1'b1; break; end
            a_in = W'($urandom); b_in = W'($urandom);
            @(posedge clk); #1;
        end
        total++; if (!got || {cout, sum} !== ex) begin
            bad++; $display("FAIL held_first: got %h done=%b expected %h", {cout, sum}, got, ex);
        end
        a_in = ya; b_in = yb;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (busy !== 1'b1 || done !== 1'b0) begin
            bad++; $display("FAIL b2b_no_idle: got busy=%b done=%b expected 1 0", busy, done);
        end
        bc = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin got = 1'b1; break; end
            if (busy) bc++;
            @(posedge clk); #1;
        end
        total++; if (!got || {cout, sum} !== ey || bc != W) begin
            bad++; $display("FAIL b2b_second: got %h busy=%0d expected %h busy=%0d", {cout, sum}, bc, ey, W);
        end
    endtask

    task automatic test_reset_mid();
        logic [W:0] res;
        int bc; bit to, ov, mv, seen;
        @(posedge clk); #1;
        start = 1'b1; a_in = 8'h7E; b_in = 8'h33;
`ifdef CARRY_IN_EN
        cin = 1'b0;
`endif
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL midrst_ctrl: got busy=%b done=%b expected 0 0", busy, done);
        end
        total++; if (sum !== '0 || cout !== 1'b0) begin
            bad++; $display("FAIL midrst_result: got %h expected 000", {cout, sum});
        end
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            if (done || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen) begin bad++; $display("FAIL midrst_no_done: got activity=1 expected 0"); end
        do_add(8'h03, 8'h04, 1'b0, res, bc, to, ov, mv);
        total++; if (to || res !== 9'h007) begin
            bad++; $display("FAIL midrst_fresh: got %h timeout=%b expected 007", res, to);
        end
    endtask

    task automatic test_width1();
        logic [1:0] exp, got_v;
        logic       ai, bi, ci;
        int bc; bit got;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin ai = 1'b1; bi = 1'b1; end
            else begin ai = 1'($urandom); bi = 1'($urandom); end
            ci = (CIN_EN && k > 0) ? 1'($urandom) : 1'b0;
            exp = 2'(int'(ai) + int'(bi) + int'(ci));
            @(posedge clk); #1;
            start1 = 1'b1; a1 = ai; b1 = bi;
`ifdef CARRY_IN_EN
            cin1 = ci;
`endif
            @(posedge clk); #1;
            start1 = 1'b0;
            bc = 0; got = 1'b0; got_v = 2'b00;
            for (int i = 0; i < 10; i++) begin
                if (done1) begin got = 1'b1; got_v = {cout1, sum1}; break; end
                if (busy1) bc++;
                @(posedge clk); #1;
            end
            total++; if (!got || got_v !== exp || bc != 1) begin
                bad++; $display("FAIL w1[%0d]: got %b busy=%0d done=%b expected %b busy=1", k, got_v, bc, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_reset_mid();
        test_width1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
